alu_muldiv_seq: RTL
===================

# alu_muldiv_seq

Multi-cycle sequencer for the M-extension operations that the ALU decoder encodes as ALU_op 13 (mul), 14 (div) and 15 (mod). It accepts one operation at a time over a valid/ready handshake and iterates a shared shift-add/shift-subtract datapath for WIDTH cycles. It applies RISC-V sign and corner-case rules and returns the result over a second valid/ready handshake. It sits beside the single-cycle ALU in the execute stage; the pipeline stalls while req_ready or resp_valid holds it off.

## Interface
- WIDTH, 32: operand/result width; iteration count equals WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  operation request.
- req_ready  out  1  high only in IDLE.
- alu_op  in  4  13 = mul, 14 = div, 15 = mod; other codes per Operation.
- a  in  WIDTH  operand A (dividend / multiplicand), two's complement.
- b  in  WIDTH  operand B (divisor / multiplier), two's complement.
- flush  in  1  synchronous abort of the in-flight operation.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- result  out  WIDTH  result; held stable while resp_valid && !resp_ready.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On req_valid, latch a, b, op, and sign flags; clear the 6-bit iteration counter.
  - Go to CALC, except for the special cases below, which go to DONE with the result preloaded.
- Special cases, detected at accept:
  - div/mod with b == 0: div = all ones, mod = a.
  - div/mod with a = most-negative value and b = -1: div = a, mod = 0.
  - alu_op not in 13..15: result 0.
- CALC, mul:
  - Shift-add on raw operands.
  - result = low WIDTH bits of a*b; signedness is irrelevant to the low half.
- CALC, div/mod:
  - Restoring division on |a| and |b|.
  - Produces quotient magnitude q and remainder magnitude r.
- CALC exit: counter increments each cycle; after WIDTH iterations (counter == WIDTH-1 on exit edge) go to FIX.
- FIX:
  - div: negate q if sign(a) != sign(b).
  - mod: negate r if sign(a) = 1, so the remainder takes the sign of the dividend.
  - mul: pass through.
  - Go to DONE.
- DONE:
  - resp_valid = 1.
  - On resp_ready, go to IDLE in the same handshake cycle.
- flush:
  - In CALC or FIX, returns to IDLE next edge with no response.
  - Ignored in IDLE and DONE; a result already in DONE is still delivered.
- Arithmetic: remainder register WIDTH+1 bits for the trial subtract; multiplier accumulator WIDTH bits, with overflow discarded.

## Timing
- Reset values: req_ready = 1, resp_valid = 0, busy = 0, result = 0, state IDLE, counter 0.
- Accept edge at end of cycle T, when req_valid && req_ready.
- Normal path: CALC occupies T+1..T+WIDTH, FIX occupies T+WIDTH+1, resp_valid rises in T+WIDTH+2 (T+34 for WIDTH = 32).
- Special-case path: resp_valid in T+1.
- Issue rate: req_ready is low from T+1 until the cycle after the response handshake; the next accept is no earlier than one cycle after resp_ready is sampled high.
- Back-to-back issue is not supported: no request can be accepted in the DONE handshake cycle.
- resp_ready high in IDLE or CALC has no effect.
- Reset mid-operation returns all outputs to reset values immediately; the pending result is lost.

## Structure
- Shared package alu_pkg:
  - ALU_OP_MUL = 4'd13, ALU_OP_DIV = 4'd14, ALU_OP_MOD = 4'd15.
  - State enum muldiv_state_t.
  - The same package holds the decoder's other op codes.
- One sub-module, muldiv_step: combinational single iteration.
  - Inputs: op, accumulator/remainder, shift registers.
  - Outputs: next-state values for the datapath.
- The FSM, counter and sign/fix logic stay in alu_muldiv_seq.

## Test plan
- mul a = 7, b = -3 (0xFFFFFFFD), accept at T -> resp_valid at T+34, result 0xFFFFFFEB; busy high T+1..T+34.
- div a = -7, b = 2 -> 0xFFFFFFFD; mod same operands -> 0xFFFFFFFF; mod a = 7, b = -2 -> 0x00000001.
- div 5/0 -> 0xFFFFFFFF at T+1; mod 5%0 -> 0x00000005; div 0x80000000 / 0xFFFFFFFF -> 0x80000000, mod -> 0.
- Backpressure: mul 3*4 with resp_ready low for 5 cycles after resp_valid -> result holds 0x0000000C, req_ready stays 0, a new req_valid is not accepted; handshake -> req_ready = 1 next cycle.
- flush at T+10 of a div -> IDLE at T+11, resp_valid never asserted; next request completes normally.
- rst asserted at T+20 asynchronously -> outputs at reset values before the next edge; a following mul 2*2 returns 4 at T'+34.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions for the execute stage.
//   - alu_op_t codes used by the ALU decoder (13..15 are the M-extension ops
//     handled by the multi-cycle sequencer alu_muldiv_seq).
//   - muldiv_state_t : state encoding of the mul/div sequencer.
//   - is_muldiv_op() : true for the codes the sequencer actually computes.
package alu_pkg;

  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_SUB  = 4'd1;
  localparam logic [3:0] ALU_OP_SLL  = 4'd2;
  localparam logic [3:0] ALU_OP_SLT  = 4'd3;
  localparam logic [3:0] ALU_OP_SLTU = 4'd4;
  localparam logic [3:0] ALU_OP_XOR  = 4'd5;
  localparam logic [3:0] ALU_OP_SRL  = 4'd6;
  localparam logic [3:0] ALU_OP_SRA  = 4'd7;
  localparam logic [3:0] ALU_OP_OR   = 4'd8;
  localparam logic [3:0] ALU_OP_AND  = 4'd9;
  localparam logic [3:0] ALU_OP_LUI  = 4'd10;
  localparam logic [3:0] ALU_OP_PASS = 4'd11;
  localparam logic [3:0] ALU_OP_EQ   = 4'd12;
  localparam logic [3:0] ALU_OP_MUL  = 4'd13;
  localparam logic [3:0] ALU_OP_DIV  = 4'd14;
  localparam logic [3:0] ALU_OP_MOD  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  function automatic logic is_muldiv_op(input logic [3:0] op);
    return (op == ALU_OP_MUL) || (op == ALU_OP_DIV) || (op == ALU_OP_MOD);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared mul/div datapath (purely combinational).
//   is_mul    : 1 = shift-add multiply step, 0 = restoring divide step
//   acc       : WIDTH+1 bit accumulator (mul, low WIDTH bits) / remainder (div)
//   sh_a      : multiplicand (mul, shifts left) / dividend-quotient (div)
//   sh_b      : multiplier (mul, shifts right) / divisor magnitude (div, constant)
//   *_next    : register values after this iteration
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_mul,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] sh_a,
  input  logic [WIDTH-1:0] sh_b,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] sh_a_next,
  output logic [WIDTH-1:0] sh_b_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  // NOTE: every output and temporary gets a default at the top of the block,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    acc_next  = acc;
    sh_a_next = sh_a;
    sh_b_next = sh_b;
    addend    = '0;
    sum       = '0;
    rem_sh    = '0;
    trial     = '0;
    if (is_mul) begin
      // Low half only: the carry out of the WIDTH-bit add is discarded.
      addend    = sh_b[0] ? sh_a : '0;
      sum       = acc[WIDTH-1:0] + addend;
      acc_next  = {1'b0, sum};
      sh_a_next = sh_a << 1;
      sh_b_next = sh_b >> 1;
    end else begin
      // The dividend is consumed MSB-first from sh_a while quotient bits
      // enter at the LSB; bit WIDTH of the trial difference is its sign.
      rem_sh    = {acc[WIDTH-1:0], sh_a[WIDTH-1]};
      trial     = rem_sh - {1'b0, sh_b};
      sh_a_next = {sh_a[WIDTH-2:0], ~trial[WIDTH]};
      acc_next  = trial[WIDTH] ? rem_sh : trial;
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle sequencer for RISC-V mul / div / rem (ALU ops 13/14/15).
//   clk, rst           : clock, asynchronous active-high reset
//   req_valid/req_ready: operation request handshake (ready only in IDLE)
//   alu_op, a, b       : operation code and two's complement operands
//   flush              : abort an operation in CALC or FIX, no response
//   resp_valid/ready   : result handshake; result held while stalled
//   result             : operation result
//   busy               : sequencer not in IDLE
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [5:0]       LAST_IT  = 6'(WIDTH - 1);

  muldiv_state_t    state, state_next;
  logic [5:0]       count;
  logic [3:0]       op_q;
  logic             neg_q;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] sh_a_next;
  logic [WIDTH-1:0] sh_b_next;

  // Accept-time decode
  logic             accept;
  logic             in_divmod;
  logic             special;
  logic [WIDTH-1:0] special_val;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] fixed_val;

  assign accept    = req_valid && (state == IDLE);
  assign in_divmod = (alu_op == ALU_OP_DIV) || (alu_op == ALU_OP_MOD);
  assign a_abs     = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_abs     = b[WIDTH-1] ? (~b + 1'b1) : b;

  always_comb begin
    special     = 1'b0;
    special_val = '0;
    if (!is_muldiv_op(alu_op)) begin
      special     = 1'b1;
      special_val = '0;
    end else if (in_divmod && (b == '0)) begin
      special     = 1'b1;
      special_val = (alu_op == ALU_OP_DIV) ? '1 : a;
    end else if (in_divmod && (a == MOST_NEG) && (b == '1)) begin
      // Signed overflow: the quotient wraps back to the dividend.
      special     = 1'b1;
      special_val = (alu_op == ALU_OP_DIV) ? a : '0;
    end
  end

  // Sign correction applied in FIX; neg_q already folds in the op's rule.
  always_comb begin
    fixed_val = acc[WIDTH-1:0];
    case (op_q)
      ALU_OP_DIV: fixed_val = neg_q ? (~sh_a + 1'b1) : sh_a;
      ALU_OP_MOD: fixed_val = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
      default:    fixed_val = acc[WIDTH-1:0];
    endcase
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_mul    (op_q == ALU_OP_MUL),
    .acc       (acc),
    .sh_a      (sh_a),
    .sh_b      (sh_b),
    .acc_next  (acc_next),
    .sh_a_next (sh_a_next),
    .sh_b_next (sh_b_next)
  );

  // State register
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (req_valid) state_next = special ? DONE : CALC;
      CALC: begin
        if (flush)                 state_next = IDLE;
        else if (count == LAST_IT) state_next = FIX;
      end
      FIX:  state_next = flush ? IDLE : DONE;
      DONE: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath, counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc      <= '0;
      sh_a     <= '0;
      sh_b     <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q  <= alu_op;
          count <= '0;
          acc   <= '0;
          if (alu_op == ALU_OP_DIV)      neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
          else if (alu_op == ALU_OP_MOD) neg_q <= a[WIDTH-1];
          else                           neg_q <= 1'b0;
          // Multiply works on raw operands; divide on magnitudes.
          sh_a  <= in_divmod ? a_abs : a;
          sh_b  <= in_divmod ? b_abs : b;
          if (special) result_q <= special_val;
        end
        CALC: if (!flush) begin
          acc   <= acc_next;
          sh_a  <= sh_a_next;
          sh_b  <= sh_b_next;
          count <= count + 6'd1;
        end
        FIX: if (!flush) result_q <= fixed_val;
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);
  assign result     = result_q;

endmodule
